// File: rtl/logo_ctrl_pkg.sv
// Shared geometry and FSM encoding for the flying-logo position controller.
// X_MAX/Y_MAX are the largest legal top-left coordinates that keep the logo on screen.
package logo_ctrl_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int LOGO_W   = 120;
  localparam int LOGO_H   = 160;
  localparam int X_MAX    = H_ACTIVE - LOGO_W;
  localparam int Y_MAX    = V_ACTIVE - LOGO_H;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/logo_motion_ctrl_btn_frame_filter.sv
// Per-button synchronizer plus frame-rate hold counter; the button is active
// once it has been seen high on HOLD_FRAMES consecutive frame ticks.
module btn_frame_filter
  import logo_ctrl_pkg::*;
#(
  parameter int HOLD_FRAMES = 2
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic btn,
  input  logic frame_tick,
  output logic active
);

  logic       btn_s1;
  logic       btn_s2;
  logic [2:0] hold_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Counter only moves on frame ticks, so a bounce shorter than a frame never registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 3'd0;
    end else if (frame_tick) begin
      if (!btn_s2)
        hold_cnt <= 3'd0;
      else if (hold_cnt != 3'd7)
        hold_cnt <= hold_cnt + 3'd1;
    end
  end

  assign active = (hold_cnt >= 3'(HOLD_FRAMES));

endmodule

// File: rtl/logo_motion_ctrl.sv
// Frame-synchronous position controller for the 120x160 logo on 640x480 VGA.
// Define AUTO_BOUNCE_EN to add autonomous edge-bouncing flight selected by auto_mode.
module logo_motion_ctrl
  import logo_ctrl_pkg::*;
#(
  parameter int X_INIT      = 260,
  parameter int Y_INIT      = 160,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       auto_mode,
  output logic [9:0] logo_x,
  output logic [9:0] logo_y,
  output logic       frame_tick,
  output logic       moving
);

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  state_t state, state_nxt;

  logic vs_s1, vs_s2, vs_d;
  logic act_up, act_down, act_left, act_right;
  logic signed [10:0] step_x, step_y;
  logic signed [10:0] cand_x, cand_y;
  logic [9:0] new_x, new_y;

  // vsync idles high, so its flops reset high to avoid a false tick after reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vsync;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      frame_tick <= vs_d & ~vs_s2;
    end
  end

  btn_frame_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_flt_up (
    .pclk(pclk), .rst_n(rst_n), .btn(btn_up), .frame_tick(frame_tick), .active(act_up));
  btn_frame_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_flt_down (
    .pclk(pclk), .rst_n(rst_n), .btn(btn_down), .frame_tick(frame_tick), .active(act_down));
  btn_frame_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_flt_left (
    .pclk(pclk), .rst_n(rst_n), .btn(btn_left), .frame_tick(frame_tick), .active(act_left));
  btn_frame_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_flt_right (
    .pclk(pclk), .rst_n(rst_n), .btn(btn_right), .frame_tick(frame_tick), .active(act_right));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (frame_tick) state_nxt = S_CALC;
      S_CALC:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

`ifdef AUTO_BOUNCE_EN
  logic auto_s1, auto_s2, auto_lat;
  logic dx_neg, dy_neg;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      auto_s1  <= 1'b0;
      auto_s2  <= 1'b0;
      auto_lat <= 1'b0;
    end else begin
      auto_s1 <= auto_mode;
      auto_s2 <= auto_s1;
      if (frame_tick && state == S_WAIT)
        auto_lat <= auto_s2;
    end
  end

  // Touching a limit reverses the axis, so the next frame already moves away from it.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (state == S_COMMIT && auto_lat) begin
      if (cand_x <= 11'sd0)        dx_neg <= 1'b0;
      else if (cand_x >= X_MAX_S)  dx_neg <= 1'b1;
      if (cand_y <= 11'sd0)        dy_neg <= 1'b0;
      else if (cand_y >= Y_MAX_S)  dy_neg <= 1'b1;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = auto_mode;
`endif

  always_comb begin
    step_x = '0;
    step_y = '0;
    if (act_right && !act_left)      step_x = STEP_S;
    else if (act_left && !act_right) step_x = -STEP_S;
    if (act_down && !act_up)         step_y = STEP_S;
    else if (act_up && !act_down)    step_y = -STEP_S;
`ifdef AUTO_BOUNCE_EN
    if (auto_lat) begin
      step_x = dx_neg ? -STEP_S : STEP_S;
      step_y = dy_neg ? -STEP_S : STEP_S;
    end
`endif
  end

  always_comb begin
    new_x = cand_x[9:0];
    new_y = cand_y[9:0];
    if (cand_x <= 11'sd0)       new_x = 10'd0;
    else if (cand_x >= X_MAX_S) new_x = 10'(X_MAX);
    if (cand_y <= 11'sd0)       new_y = 10'd0;
    else if (cand_y >= Y_MAX_S) new_y = 10'(Y_MAX);
  end

  // Candidates are widened to 11-bit signed so moves past either edge cannot wrap.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      logo_x <= 10'(X_INIT);
      logo_y <= 10'(Y_INIT);
      moving <= 1'b0;
      cand_x <= '0;
      cand_y <= '0;
    end else begin
      if (state == S_CALC) begin
        cand_x <= $signed({1'b0, logo_x}) + step_x;
        cand_y <= $signed({1'b0, logo_y}) + step_y;
      end
      if (state == S_COMMIT) begin
        logo_x <= new_x;
        logo_y <= new_y;
        moving <= (new_x != logo_x) || (new_y != logo_y);
      end
    end
  end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed bench for logo_motion_ctrl: reset, button moves, clamping, opposing
// buttons, reset during an update and, with AUTO_BOUNCE_EN, edge bouncing.
module tb_logo_motion_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       btn_up, btn_down, btn_left, btn_right, auto_mode;
  logic [9:0] logo_x, logo_y;
  logic       frame_tick, moving;

  int n_compared   = 0;
  int n_mismatched = 0;

  logo_motion_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .auto_mode(auto_mode),
    .logo_x(logo_x), .logo_y(logo_y), .frame_tick(frame_tick), .moving(moving)
  );

  always #20 pclk = ~pclk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Falls vsync, waits for the tick (bounded), then returns once the commit is visible.
  task automatic run_frame();
    int n;
    @(negedge pclk) vsync = 1'b0;
    n = 0;
    while (frame_tick !== 1'b1 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    n_compared++;
    if (frame_tick !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL frame_tick_timeout: got %b after %0d cycles, need 1", frame_tick, n);
    end
    repeat (3) @(negedge pclk);
    vsync = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; auto_mode = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (3) @(negedge pclk);
    n_compared += 4;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL rst_x: got %0d need 260", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL rst_y: got %0d need 160", logo_y); end
    if (frame_tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_tick: got %b need 0", frame_tick); end
    if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_moving: got %b need 0", moving); end
    rst_n = 1'b1;
    repeat (4) @(negedge pclk);
    // tick timing: low after edges 1 and 2, high after edge 3, low again after edge 4
    vsync = 1'b0;
    repeat (2) @(negedge pclk);
    n_compared++;
    if (frame_tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tick_early: got %b need 0", frame_tick); end
    @(negedge pclk);
    n_compared++;
    if (frame_tick !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tick_edge3: got %b need 1", frame_tick); end
    @(negedge pclk);
    n_compared++;
    if (frame_tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tick_width: got %b need 0", frame_tick); end
    repeat (2) @(negedge pclk);
    vsync = 1'b1;
    repeat (8) @(negedge pclk);
    for (int f = 0; f < 4; f++) run_frame();
    n_compared += 3;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL idle_x: got %0d need 260", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL idle_y: got %0d need 160", logo_y); end
    if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_moving: got %b need 0", moving); end
  endtask

  task automatic test_right_move();
    int n;
    btn_right = 1'b1;
    repeat (4) @(negedge pclk);
    run_frame();
    n_compared += 2;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL hold1_x: got %0d need 260", logo_x); end
    if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold1_moving: got %b need 0", moving); end
    @(negedge pclk) vsync = 1'b0;
    n = 0;
    while (frame_tick !== 1'b1 && n < 10) begin @(negedge pclk); n++; end
    n_compared++;
    if (frame_tick !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tick2_timeout: got %b need 1", frame_tick); end
    repeat (2) @(negedge pclk);
    n_compared++;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL latency_early: got %0d need 260", logo_x); end
    @(negedge pclk);
    n_compared += 2;
    if (logo_x !== 10'd261) begin n_mismatched++; $display("[TB] FAIL latency_x: got %0d need 261", logo_x); end
    if (moving !== 1'b1) begin n_mismatched++; $display("[TB] FAIL move_flag: got %b need 1", moving); end
    vsync = 1'b1;
    repeat (8) @(negedge pclk);
    run_frame();
    n_compared++;
    if (logo_x !== 10'd262) begin n_mismatched++; $display("[TB] FAIL right_262: got %0d need 262", logo_x); end
    run_frame();
    n_compared += 2;
    if (logo_x !== 10'd263) begin n_mismatched++; $display("[TB] FAIL right_263: got %0d need 263", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL right_y: got %0d need 160", logo_y); end
  endtask

  task automatic test_saturate();
    logic [9:0] exp_x [4];
    logic       exp_m [4];
    exp_x[0] = 10'd519; exp_x[1] = 10'd520; exp_x[2] = 10'd520; exp_x[3] = 10'd520;
    exp_m[0] = 1'b1;    exp_m[1] = 1'b1;    exp_m[2] = 1'b0;    exp_m[3] = 1'b0;
    for (int f = 0; f < 255; f++) run_frame();
    n_compared++;
    if (logo_x !== 10'd518) begin n_mismatched++; $display("[TB] FAIL sat_start: got %0d need 518", logo_x); end
    for (int i = 0; i < 4; i++) begin
      run_frame();
      n_compared += 2;
      if (logo_x !== exp_x[i]) begin
        n_mismatched++; $display("[TB] FAIL sat_x[%0d]: got %0d need %0d", i, logo_x, exp_x[i]);
      end
      if (moving !== exp_m[i]) begin
        n_mismatched++; $display("[TB] FAIL sat_moving[%0d]: got %b need %b", i, moving, exp_m[i]);
      end
    end
    btn_right = 1'b0;
    run_frame();
  endtask

  task automatic test_up_down();
    btn_up = 1'b1; btn_down = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_frame();
      n_compared += 2;
      if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL updown_y[%0d]: got %0d need 160", f, logo_y); end
      if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL updown_moving[%0d]: got %b need 0", f, moving); end
    end
    btn_left = 1'b1;
    run_frame();
    run_frame();
    n_compared += 3;
    if (logo_x !== 10'd519) begin n_mismatched++; $display("[TB] FAIL left_519: got %0d need 519", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL left_y: got %0d need 160", logo_y); end
    if (moving !== 1'b1) begin n_mismatched++; $display("[TB] FAIL left_moving: got %b need 1", moving); end
    run_frame();
    n_compared++;
    if (logo_x !== 10'd518) begin n_mismatched++; $display("[TB] FAIL left_518: got %0d need 518", logo_x); end
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    run_frame();
  endtask

  task automatic test_reset_mid();
    int n;
    btn_left = 1'b1;
    run_frame();
    run_frame();
    n_compared++;
    if (logo_x !== 10'd517) begin n_mismatched++; $display("[TB] FAIL pre_reset_x: got %0d need 517", logo_x); end
    @(negedge pclk) vsync = 1'b0;
    n = 0;
    while (frame_tick !== 1'b1 && n < 10) begin @(negedge pclk); n++; end
    @(posedge pclk);
    #1;
    rst_n = 1'b0;
    vsync = 1'b1;
    btn_left = 1'b0;
    #1;
    n_compared += 4;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL mid_rst_x: got %0d need 260", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL mid_rst_y: got %0d need 160", logo_y); end
    if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_moving: got %b need 0", moving); end
    if (frame_tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_tick: got %b need 0", frame_tick); end
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    repeat (10) @(negedge pclk);
    n_compared++;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL no_commit_x: got %0d need 260", logo_x); end
    run_frame();
    n_compared += 3;
    if (logo_x !== 10'd260) begin n_mismatched++; $display("[TB] FAIL post_rst_x: got %0d need 260", logo_x); end
    if (logo_y !== 10'd160) begin n_mismatched++; $display("[TB] FAIL post_rst_y: got %0d need 160", logo_y); end
    if (moving !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_rst_moving: got %b need 0", moving); end
  endtask

`ifdef AUTO_BOUNCE_EN
  // From reset: x = 260+k up to 520 at k=260; y = 160+k up to 320 at k=160, then down to 0 at k=480.
  task automatic test_auto_bounce();
    @(negedge pclk) rst_n = 1'b0;
    auto_mode = 1'b1;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    repeat (4) @(negedge pclk);
    for (int k = 1; k <= 481; k++) begin
      run_frame();
      if (k == 1) begin
        n_compared += 2;
        if (logo_x !== 10'd261 || logo_y !== 10'd161) begin
          n_mismatched++; $display("[TB] FAIL auto_k1: got %0d/%0d need 261/161", logo_x, logo_y);
        end
        if (moving !== 1'b1) begin n_mismatched++; $display("[TB] FAIL auto_moving: got %b need 1", moving); end
      end
      if (k == 160 || k == 161) begin
        n_compared++;
        if (logo_y !== (k == 160 ? 10'd320 : 10'd319)) begin
          n_mismatched++; $display("[TB] FAIL auto_ybot k=%0d: got %0d", k, logo_y);
        end
      end
      if (k >= 259 && k <= 262) begin
        n_compared++;
        if (logo_x !== 10'(k <= 260 ? 260 + k : 780 - k)) begin
          n_mismatched++; $display("[TB] FAIL auto_xbounce k=%0d: got %0d need %0d", k, logo_x, (k <= 260 ? 260 + k : 780 - k));
        end
      end
      if (k == 480 || k == 481) begin
        n_compared++;
        if (logo_y !== (k == 480 ? 10'd0 : 10'd1)) begin
          n_mismatched++; $display("[TB] FAIL auto_ytop k=%0d: got %0d", k, logo_y);
        end
      end
    end
    auto_mode = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_right_move();
    test_saturate();
    test_up_down();
    test_reset_mid();
`ifdef AUTO_BOUNCE_EN
    test_auto_bounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
